// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-port unified memory arbiter between Fetch and Memory stages
// Three-state transaction FSM with round-robin conflict resolution and per-stage stall requests.
module unified_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              StallIF,
  output logic              StallMEM
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                dm_done_q, dm_done_d;
  logic                data_req;

  assign data_req = dm_read | dm_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_FETCH;
      last_grant_q <= GRANT_FETCH;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      rdata_q      <= '0;
      if_valid_q   <= 1'b0;
      dm_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      rdata_q      <= rdata_d;
      if_valid_q   <= if_valid_d;
      dm_done_q    <= dm_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    rdata_d      = rdata_q;
    if_valid_d   = 1'b0;
    dm_done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_req || if_req) begin
          // On contention the side that was not served last wins.
          if (data_req && if_req) grant_d = ~last_grant_q;
          else if (data_req)      grant_d = GRANT_DATA;
          else                    grant_d = GRANT_FETCH;
          last_grant_d = grant_d;
          if (grant_d == GRANT_DATA) begin
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
            we_d    = dm_write;
          end else begin
            addr_d  = if_addr;
            wdata_d = '0;
            we_d    = 1'b0;
          end
          state_d = XFER;
        end
      end
      XFER: begin
        if (mem_ready) begin
          if (!we_q) rdata_d = mem_rdata;
          if (grant_q == GRANT_DATA) dm_done_d  = 1'b1;
          else                       if_valid_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_en    = (state_q == XFER);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = rdata_q;
  assign dm_rdata  = rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_done   = dm_done_q;
  assign StallIF   = if_req & ~if_valid_q;
  assign StallMEM  = data_req & ~dm_done_q;

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbitrates one single-port unified instruction/data memory between the Fetch stage (instruction reads) and the Memory stage (loads/stores) of the pipelined processor. Runs a three-state transaction FSM against a variable-latency memory (ready handshake) and applies round-robin priority on conflicts. Generates per-stage stall requests that the hazard logic ORs into its StallF/StallD/FlushE and Memory-stage hold terms.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- if_req  in  1  Fetch requests an instruction read
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction, valid when if_valid=1
- if_valid  out  1  one-cycle fetch-completion pulse
- dm_read  in  1  Memory-stage load request (MemtoRegM)
- dm_write  in  1  Memory-stage store request (MemWriteM)
- dm_addr  in  ADDR_W  data address (ALUOutM)
- dm_wdata  in  DATA_W  store data (WriteDataM)
- dm_rdata  out  DATA_W  load data, valid when dm_done=1
- dm_done  out  1  one-cycle data-completion pulse
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable, meaningful only with mem_en=1
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, sampled when mem_ready=1
- mem_ready  in  1  memory completes current access
- StallIF  out  1  Fetch must hold (to hazard logic)
- StallMEM  out  1  Memory stage must hold (to hazard logic)

## Operation
- States: IDLE, XFER, RESP. Registers: state, grant (FETCH/DATA), last_grant, latched addr/wdata/we, rdata, if_valid, dm_done.
- Data request = dm_read | dm_write; both high -> treated as store (mem_we=1).
- IDLE: arbitration only, mem_en=0.
  - Data request only -> grant DATA; if_req only -> grant FETCH; none -> stay IDLE.
  - Both -> grant side other than last_grant (round-robin).
  - On grant: latch address, wdata, we; last_grant <= grant; next state XFER.
- XFER: mem_en=1; mem_addr/mem_wdata/mem_we driven from latched registers, stable for entire state regardless of input changes.
  - mem_ready=0 -> stay XFER (no timeout).
  - mem_ready=1 -> capture mem_rdata into rdata (reads only; stores leave rdata unchanged), set if_valid or dm_done per grant, go RESP.
- RESP: mem_en=0; if_valid/dm_done high this cycle only; no arbitration; next state IDLE unconditionally. Requester deasserts or changes its request in this cycle; IDLE re-samples next cycle.
- if_rdata and dm_rdata both driven from rdata register; hold last value between transactions.
- StallIF = if_req & ~if_valid. StallMEM = (dm_read | dm_write) & ~dm_done. Combinational from inputs and registered pulses.
- mem_ready outside XFER ignored.

## Timing
- Reset (sync, edge with rst=1): state=IDLE, last_grant=FETCH (first conflict goes to DATA), if_valid=0, dm_done=0, rdata=0, latched addr/wdata/we=0; hence mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=dm_rdata=0, and StallIF/StallMEM follow requests. Reset during XFER abandons the access: mem_en low from the cycle after the reset edge, no completion pulse.
- Request seen in IDLE at cycle N -> mem_en=1 at N+1 -> mem_ready at cycle M ≥ N+1 -> completion pulse and data at M+1 -> IDLE at M+2.
- Minimum transaction: 3 cycles (zero-wait memory); back-to-back throughput one access per 3 cycles.
- Conflict at IDLE: loser keeps stalling; served in the next IDLE after winner's RESP. No starvation: alternation guaranteed under continuous contention.
- Request dropped during XFER: access still completes; pulse still issued.

## Test plan
- Reset then if_req=1, if_addr=0x40, mem_ready=1 constant, mem_rdata=0x2010000A -> mem_en at cycle 1, if_valid=1 with if_rdata=0x2010000A at cycle 2, StallIF=1 cycles 0-1, 0 at cycle 2.
- dm_write=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, mem_ready delayed 3 cycles -> mem_we=1, mem_addr/mem_wdata stable all 3 XFER cycles, dm_done one cycle after mem_ready, rdata unchanged.
- if_req and dm_read both held from reset -> first grant DATA, then FETCH, then DATA (alternating); each StallX drops only on its pulse.
- dm_read=dm_write=1 simultaneously -> mem_we=1 (store).
- rst asserted during XFER with mem_ready=0 -> next cycle mem_en=0, state IDLE, no if_valid/dm_done pulse.
- mem_ready=1 pulsed while IDLE, no requests -> no mem_en, no pulses, rdata unchanged.
